// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_sub_state_t;

    localparam int SERIAL_SUB_N_DEFAULT = 8;

endpackage

// File: rtl/fs_nand_only.sv
// One-bit full subtractor built only from two-input nand primitives:
// d = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module fs_nand_only (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic n1, n2, n3, x;
    logic m1, m2, m3;
    logic na, nx, t1, t2;

    // x = a ^ b
    nand g_n1 (n1, a, b);
    nand g_n2 (n2, a, n1);
    nand g_n3 (n3, b, n1);
    nand g_x  (x, n2, n3);

    // d = x ^ bin
    nand g_m1 (m1, x, bin);
    nand g_m2 (m2, x, m1);
    nand g_m3 (m3, bin, m1);
    nand g_d  (d, m2, m3);

    // bout = nand(nand(~a, b), nand(~x, bin))
    nand g_na (na, a, a);
    nand g_nx (nx, x, x);
    nand g_t1 (t1, na, b);
    nand g_t2 (t2, nx, bin);
    nand g_bo (bout, t1, t2);

endmodule

// File: rtl/serial_sub_nand.sv
// Bit-serial N-bit subtractor (LSB first, one bit per clock) using a nand-only full subtractor.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nand
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    serial_sub_state_t state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fs_d, fs_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic as_q, as_d;
    logic bs_q, bs_d;
    logic ovf_q, ovf_d;
`endif

    fs_nand_only u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        as_d     = as_q;
        bs_d     = bs_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            SHIFT: begin
                busy     = 1'b1;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {fs_d, diff_q[N-1:1]};
                borrow_d = fs_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // fs_d on the last step is the result sign bit
                    ovf_d   = (as_q ^ bs_q) & (as_q ^ fs_d);
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Start is honoured from IDLE and DONE only, giving back-to-back operation from DONE
        if (start && (state_q != SHIFT)) begin
            state_d  = SHIFT;
            a_d      = a;
            b_d      = b;
            borrow_d = 1'b0;
            cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
            as_d     = a[N-1];
            bs_d     = b[N-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            as_q  <= 1'b0;
            bs_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            as_q  <= as_d;
            bs_q  <= bs_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign diff = diff_q;
    assign bout = borrow_q;

endmodule

// File: tb/tb_serial_sub_nand.sv
// Directed self-checking bench for serial_sub_nand (N=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_nand;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, bout;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int nvec = 0;
    int nmis = 0;

    serial_sub_nand #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge of the first cycle after the accepting edge; that cycle counts as 1.
    task automatic wait_done(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
        int cnt = 1;
        logic overlap = 1'b0;
        while (!done && cnt < 20) begin
            overlap |= busy & done;
            @(negedge clk);
            cnt++;
        end
        overlap |= busy & done;
        check({tag, "_lat"}, cnt, 9);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovlp"}, overlap, 0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) $display("unused %0b", eo);
`endif
    endtask

    // Entered and left on a negedge.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        check({tag, "_busy1"}, busy, 1);
        wait_done(tag, ed, eb, eo);
        @(negedge clk);
        check({tag, "_dpulse"}, done, 0);
        check({tag, "_hold"}, diff, ed);
    endtask

    typedef struct {
        logic [7:0] av, bv, ed;
        logic       eb, eo;
    } vec_t;

    vec_t tbl[6] = '{
        '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0},
        '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
        '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0},
        '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0},
        '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
        '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0}
    };

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // first op starts on the very first edge after reset release
        for (int i = 0; i < 6; i++)
            run_op($sformatf("v%0d", i), tbl[i].av, tbl[i].bv, tbl[i].ed, tbl[i].eb, tbl[i].eo);

        // start held through SHIFT with different operands must not disturb the operation
        start = 1'b1; a = 8'h5A; b = 8'h3C;
        @(negedge clk);
        a = 8'hFF; b = 8'h00;
        for (int k = 0; k < 5; k++) @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                ndone++;
                check("hold_diff", diff, 8'h1E);
                check("hold_bout", bout, 0);
            end
            @(negedge clk);
        end
        check("hold_ndone", ndone, 1);

        // back-to-back: start during the DONE cycle
        start = 1'b1; a = 8'h00; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", 8'hFF, 1'b1, 1'b0);
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        wait_done("b2b_second", 8'hF0, 1'b1, 1'b0);
        @(negedge clk);

        // asynchronous reset in the 4th SHIFT cycle
        start = 1'b1; a = 8'h5A; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("mid_busy_pre", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_diff", diff, 0);
        check("mid_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("mid_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("mid_nodone", ndone, 0);
        run_op("post_rst", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/serial_sub_nand.md
SERIAL_SUB_NAND -- requirements
Module: serial_sub_nand

Interface
REQ-001 SHALL have parameter: N, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 SHALL have port: a  input  N  minuend, captured on an accepted start.
REQ-006 SHALL have port: b  input  N  subtrahend, captured on an accepted start.
REQ-007 SHALL have port: busy  output  1  high while in SHIFT.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port: diff  output  N  result a - b, modulo 2^N.
REQ-010 SHALL have port: bout  output  1  final borrow; 1 when a < b unsigned.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 SHALL accept start only in IDLE or DONE.
- On acceptance: load a and b into shift registers, clear the borrow flop, clear the bit counter, go to SHIFT.
REQ-013 SHALL, on each clk edge in SHIFT, process exactly one bit, LSB first:
- d = a0 ^ b0 ^ bin
- bnext = (~a0 & b0) | (~(a0 ^ b0) & bin)
- d shifts into diff at the MSB end; the borrow flop takes bnext.
REQ-014 SHALL leave SHIFT after exactly N edges and go to DONE, so done is high in the (N+1)th cycle after the accepting edge.
REQ-015 SHALL hold done high for exactly one cycle.
- DONE returns to IDLE on the next edge, unless start is high on that edge; then it goes to SHIFT (back-to-back operation, no idle gap).
REQ-016 SHALL ignore start while busy=1; the operation in flight and its operands are not disturbed.
REQ-017 SHALL hold diff and bout stable from the DONE cycle until the next accepted start.
- From that start onward, diff and bout are undefined until the next done.
REQ-018 SHALL assert busy only in SHIFT and done only in DONE; busy and done are never high together.
REQ-019 SHALL produce mathematically exact results for the boundary operands a = b, a = 0 and b = 2^N-1.

Reset
REQ-020 SHALL, on rst, immediately force the following, regardless of clk:
- state = IDLE, busy = 0, done = 0, diff = 0, bout = 0, borrow flop = 0, counter = 0.
REQ-021 SHALL discard any operation in progress when rst asserts mid-operation; no done is produced for it.
REQ-022 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL recognise macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), signed two's-complement overflow = (a[N-1] ^ b[N-1]) & (a[N-1] ^ diff[N-1]).
- ovf is valid and held under the same rules as diff; it resets to 0.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Structure
REQ-024 SHALL place the following in shared package serial_sub_pkg:
- the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
- the default width constant SERIAL_SUB_N_DEFAULT = 8.
REQ-025 SHALL compute the per-bit difference and borrow in one sub-module, fs_nand_only (inputs a, b, bin; outputs d, bout).
- It is built structurally from nand primitives only, with no procedural blocks.
- serial_sub_nand instantiates it exactly once.
REQ-026 SHALL keep all sequential logic (FSM, shift registers, counter, borrow flop) in serial_sub_nand.

Verification
REQ-027 SHALL pass, with N=8: a=8'h5A, b=8'h3C, start pulse -> done exactly 9 cycles later, diff=8'h1E, bout=0.
REQ-028 SHALL pass: a=8'h00, b=8'h01 -> diff=8'hFF, bout=1; also a=8'hA5, b=8'hA5 -> diff=8'h00, bout=0.
REQ-029 SHALL pass: start held high during SHIFT with changed a and b -> the first result is unaffected and a single done follows.
- start high in the DONE cycle -> busy on the next cycle, and the second result appears 9 cycles after that start.
REQ-030 SHALL pass: rst asserted at cycle 4 of SHIFT -> busy, done, diff and bout all 0 within the same cycle, no done pulse; a new start then completes correctly.
REQ-031 SHALL pass, with SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bout=0; a=8'h10, b=8'h20 -> diff=8'hF0, ovf=0, bout=1.
